// File: rtl/clock_generator_pkg.sv
// Shared types for the programmable clock divider: global mode, channel
// state, and the raw-mode decode (the reserved encoding is treated as HALT).
package clock_generator_pkg;

   typedef enum logic [1:0] {
      MODE_RUN  = 2'd0,
      MODE_STEP = 2'd1,
      MODE_HALT = 2'd2
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HI   = 2'd1,
      ST_LO   = 2'd2
   } ch_state_e;

   // Reserved encoding 3 is folded onto HALT so the divider never runs on
   // an undefined mode.
   function automatic mode_e decode_mode(input logic [1:0] raw);
      case (raw)
         2'd0:    return MODE_RUN;
         2'd1:    return MODE_STEP;
         default: return MODE_HALT;
      endcase
   endfunction

endpackage

// File: rtl/clock_generator_if.sv
// Control/status bundle of the clock divider. The master side (board
// controller) drives mode, half-periods, loads and step requests; the slave
// side (divider) returns the divided clocks, rising-edge ticks and idle flags.
interface clock_generator_if #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 32
);
   logic [1:0]                    mode;
   logic [NUM_CH-1:0][CNT_W-1:0]  half_period;
   logic [NUM_CH-1:0]             load;
   logic                          step_req;
   logic [NUM_CH-1:0]             slow_clock;
   logic [NUM_CH-1:0]             tick;
   logic [NUM_CH-1:0]             idle;

   modport master (
      output mode, half_period, load, step_req,
      input  slow_clock, tick, idle
   );

   modport slave (
      input  mode, half_period, load, step_req,
      output slow_clock, tick, idle
   );
endinterface

// File: rtl/clock_generator_channel.sv
// One divider channel: loadable half-period, phase counter and IDLE/HI/LO
// state machine with registered slow_clock, tick and idle outputs.
module clock_generator_channel
   import clock_generator_pkg::*;
#(
   parameter int CNT_W      = 32,
   parameter int RESET_HALF = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  mode_e            mode_i,
   input  logic             step_evt_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] half_i,
   output logic             slow_clock_o,
   output logic             tick_o,
   output logic             idle_o
);

   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] HALF_INIT = CNT_W'(RESET_HALF);

   ch_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] half_q, half_d;
   logic [CNT_W-1:0] last_cnt;
   logic             phase_end;
   logic             slow_q, tick_q, idle_q;

   // Clamp the half-period to at least 1 before subtracting so H-1 never
   // underflows; >= lets a shrinking load end an over-long phase at once.
   always_comb begin
      last_cnt  = (half_q == '0) ? '0 : (half_q - ONE);
      phase_end = (cnt_q >= last_cnt);
   end

   // Next-state: HALT freezes state and counter; STEP parks in IDLE after LO.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      half_d  = load_i ? half_i : half_q;
      if (mode_i != MODE_HALT) begin
         case (state_q)
            ST_IDLE: begin
               if (mode_i == MODE_RUN || step_evt_i) begin
                  state_d = ST_HI;
                  cnt_d   = '0;
               end
            end
            ST_HI: begin
               if (phase_end) begin
                  state_d = ST_LO;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
            ST_LO: begin
               if (phase_end) begin
                  state_d = (mode_i == MODE_STEP) ? ST_IDLE : ST_HI;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // State, counter, half-period and outputs; outputs follow the next state
   // so slow_clock and tick line up with the state they describe.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         half_q  <= HALF_INIT;
         slow_q  <= 1'b0;
         tick_q  <= 1'b0;
         idle_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         half_q  <= half_d;
         slow_q  <= (state_d == ST_HI);
         tick_q  <= (state_d == ST_HI) && (state_q != ST_HI);
         idle_q  <= (state_d == ST_IDLE);
      end
   end

   assign slow_clock_o = slow_q;
   assign tick_o       = tick_q;
   assign idle_o       = idle_q;

endmodule

// File: rtl/clock_generator.sv
// Multi-channel programmable clock divider for the CPU clock tree.
// Optional build macro CLOCK_GENERATOR_STEP_SYNC_EN: step_req is treated as
// asynchronous (manual button) and passed through a 2-flop synchroniser plus
// a registered rising-edge detector, giving one step per 0->1 edge.
// Without it step_req is assumed synchronous and used directly each cycle.
module clock_generator
   import clock_generator_pkg::*;
#(
   parameter int NUM_CH     = 2,
   parameter int CNT_W      = 32,
   parameter int RESET_HALF = 1
) (
   input  logic              quick_clock,
   input  logic              reset,
   clock_generator_if.slave  bus
);

   mode_e mode_s;
   logic  step_evt;

   assign mode_s = decode_mode(bus.mode);

`ifdef CLOCK_GENERATOR_STEP_SYNC_EN
   logic sync1_q, sync2_q, prev_q, evt_q;

   // Synchronise the button and emit a single-cycle event per rising edge.
   always_ff @(posedge quick_clock) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         evt_q   <= 1'b0;
      end else begin
         sync1_q <= bus.step_req;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         evt_q   <= sync2_q & ~prev_q;
      end
   end

   assign step_evt = evt_q;
`else
   assign step_evt = bus.step_req;
`endif

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clock_generator_channel #(
         .CNT_W      (CNT_W),
         .RESET_HALF (RESET_HALF)
      ) u_ch (
         .clk_i        (quick_clock),
         .rst_i        (reset),
         .mode_i       (mode_s),
         .step_evt_i   (step_evt),
         .load_i       (bus.load[g]),
         .half_i       (bus.half_period[g]),
         .slow_clock_o (bus.slow_clock[g]),
         .tick_o       (bus.tick[g]),
         .idle_o       (bus.idle[g])
      );
   end

endmodule

// File: tb/tb_clock_generator.sv
// Bench for clock_generator: a phase-level reference model checked every
// cycle, plus directed scenarios with literal expected values.
module tb_clock_generator;

   localparam int NUM_CH = 2;
   localparam int CNT_W  = 32;
`ifdef CLOCK_GENERATOR_STEP_SYNC_EN
   localparam int SLAT = 3;
`else
   localparam int SLAT = 0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   chk_en = 1'b0;

   clock_generator_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

   clock_generator #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .RESET_HALF(1)) dut (
      .quick_clock (clk),
      .reset       (reset),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   longint m_half [NUM_CH];
   longint m_el   [NUM_CH];   // cycles already spent in current phase
   bit     m_park [NUM_CH];
   bit     m_lvl  [NUM_CH];
   bit     m_tick [NUM_CH];
   bit     req_h  [4];        // req_h[k] = step_req sampled k+1 edges ago

   always @(posedge clk) begin
      bit     evt, run, stp, halt, done;
      longint h;
      if (reset) begin
         for (int c = 0; c < NUM_CH; c++) begin
            m_half[c] = 1; m_el[c] = 0; m_park[c] = 1; m_lvl[c] = 0; m_tick[c] = 0;
         end
         for (int k = 0; k < 4; k++) req_h[k] = 0;
      end else begin
`ifdef CLOCK_GENERATOR_STEP_SYNC_EN
         evt = req_h[2] & ~req_h[3];
`else
         evt = bus.step_req;
`endif
         run  = (bus.mode == 2'd0);
         stp  = (bus.mode == 2'd1);
         halt = !run && !stp;
         for (int c = 0; c < NUM_CH; c++) begin
            h    = (m_half[c] == 0) ? 1 : m_half[c];
            done = (m_el[c] + 1 >= h);
            m_tick[c] = 0;
            if (!halt) begin
               if (m_park[c]) begin
                  if (run || evt) begin
                     m_park[c] = 0; m_lvl[c] = 1; m_el[c] = 0; m_tick[c] = 1;
                  end
               end else if (done) begin
                  m_el[c] = 0;
                  if (m_lvl[c]) m_lvl[c] = 0;
                  else if (stp) m_park[c] = 1;
                  else begin m_lvl[c] = 1; m_tick[c] = 1; end
               end else begin
                  m_el[c] = m_el[c] + 1;
               end
            end
            if (bus.load[c]) m_half[c] = longint'(bus.half_period[c]);
         end
         for (int k = 3; k > 0; k--) req_h[k] = req_h[k-1];
         req_h[0] = bus.step_req;
      end
   end

   task automatic cmp(string nm, int ch, logic act, logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s ch%0d: got %b expected %b at %0t", nm, ch, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int c = 0; c < NUM_CH; c++) begin
            cmp("model_slow", c, bus.slow_clock[c], !m_park[c] && m_lvl[c]);
            cmp("model_tick", c, bus.tick[c], m_tick[c]);
            cmp("model_idle", c, bus.idle[c], m_park[c]);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic lit(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      int nt;
      reset = 1'b1; bus.mode = 2'd0; bus.load = '0; bus.step_req = 1'b0;
      bus.half_period = '0;
      cyc(2);
      chk_en = 1'b1;
      lit("rst_slow", 32'(bus.slow_clock), 32'b00);
      lit("rst_tick", 32'(bus.tick), 32'b00);
      lit("rst_idle", 32'(bus.idle), 32'b11);

      // RUN with half {1,4}, loaded while halted
      reset = 1'b0; bus.mode = 2'd2; bus.load = 2'b11;
      bus.half_period[0] = 32'd1; bus.half_period[1] = 32'd4;
      cyc(1);
      bus.load = '0; bus.mode = 2'd0;
      cyc(1);
      lit("run_start_slow", 32'(bus.slow_clock), 32'b11);
      lit("run_start_tick", 32'(bus.tick), 32'b11);
      lit("run_start_idle", 32'(bus.idle), 32'b00);
      cyc(1);
      lit("run_ch0_toggle", 32'(bus.slow_clock), 32'b10);
      cyc(7);
      lit("run_period8_tick", 32'(bus.tick), 32'b11);
      cyc(8);

      // STEP, H=3
      bus.mode = 2'd1;
      cyc(20);
      lit("step_parked", 32'(bus.idle), 32'b11);
      bus.load = 2'b11; bus.half_period[0] = 32'd3; bus.half_period[1] = 32'd3;
      cyc(1);
      bus.load = '0;
      bus.step_req = 1'b1; cyc(1); bus.step_req = 1'b0; cyc(SLAT);
      lit("step_hi_slow", 32'(bus.slow_clock), 32'b11);
      lit("step_hi_tick", 32'(bus.tick), 32'b11);
      bus.step_req = 1'b1; cyc(1); bus.step_req = 1'b0;
      cyc(2);
      lit("step_lo", 32'(bus.slow_clock), 32'b00);
      cyc(3);
      lit("step_done_idle", 32'(bus.idle), 32'b11);
      cyc(4 + SLAT);
      lit("step_not_queued_slow", 32'(bus.slow_clock), 32'b00);
      lit("step_not_queued_idle", 32'(bus.idle), 32'b11);

      // RUN H=5 with HALT at count 2 of HI
      bus.load = 2'b11; bus.half_period[0] = 32'd5; bus.half_period[1] = 32'd5;
      cyc(1);
      bus.load = '0; bus.mode = 2'd0;
      cyc(1);
      lit("h5_hi", 32'(bus.slow_clock), 32'b11);
      cyc(2);
      bus.mode = 2'd2;
      cyc(1);
      lit("halt_slow", 32'(bus.slow_clock), 32'b11);
      lit("halt_tick", 32'(bus.tick), 32'b00);
      cyc(9);
      lit("halt_hold", 32'(bus.slow_clock), 32'b11);
      bus.mode = 2'd0;
      cyc(2);
      lit("resume_two_more", 32'(bus.slow_clock), 32'b11);
      cyc(1);
      lit("resume_end", 32'(bus.slow_clock), 32'b00);

      // Shrinking load mid-HI, then load 0
      reset = 1'b1; cyc(1);
      reset = 1'b0; bus.mode = 2'd2; bus.load = 2'b10; bus.half_period[1] = 32'd10;
      cyc(1);
      bus.load = '0; bus.mode = 2'd0;
      cyc(7);
      lit("h10_cnt6", 32'(bus.slow_clock[1]), 32'd1);
      bus.load = 2'b10; bus.half_period[1] = 32'd4;
      cyc(1);
      bus.load = '0;
      lit("shrink_still_hi", 32'(bus.slow_clock[1]), 32'd1);
      cyc(1);
      lit("shrink_end", 32'(bus.slow_clock[1]), 32'd0);
      cyc(3);
      lit("lo4_mid", 32'(bus.slow_clock[1]), 32'd0);
      cyc(1);
      lit("lo4_end", 32'(bus.slow_clock[1]), 32'd1);
      lit("lo4_end_tick", 32'(bus.tick[1]), 32'd1);
      bus.load = 2'b10; bus.half_period[1] = 32'd0;
      cyc(1);
      bus.load = '0;
      cyc(1);
      lit("h0_lo", 32'(bus.slow_clock[1]), 32'd0);
      cyc(1);
      lit("h0_hi", 32'(bus.slow_clock[1]), 32'd1);

      // Reset mid-HI dominating a load
      reset = 1'b1; bus.load = 2'b11;
      bus.half_period[0] = 32'd7; bus.half_period[1] = 32'd7;
      cyc(1);
      lit("rstmid_slow", 32'(bus.slow_clock), 32'b00);
      lit("rstmid_idle", 32'(bus.idle), 32'b11);
      reset = 1'b0; bus.load = '0; bus.mode = 2'd0;
      cyc(1);
      lit("after_rst_hi", 32'(bus.slow_clock), 32'b11);
      cyc(1);
      lit("rst_beats_load", 32'(bus.slow_clock), 32'b00);

      // Reset mid-STEP pulse
      bus.mode = 2'd1;
      cyc(4);
      bus.step_req = 1'b1; cyc(1); bus.step_req = 1'b0; cyc(SLAT);
      lit("step2_hi", 32'(bus.slow_clock), 32'b11);
      reset = 1'b1;
      cyc(1);
      lit("rststep_slow", 32'(bus.slow_clock), 32'b00);
      lit("rststep_tick", 32'(bus.tick), 32'b00);
      lit("rststep_idle", 32'(bus.idle), 32'b11);
      reset = 1'b0; bus.mode = 2'd0;
      cyc(1);
      lit("rststep_run_hi", 32'(bus.slow_clock), 32'b11);

`ifdef CLOCK_GENERATOR_STEP_SYNC_EN
      // Held button gives one step, HI four edges after the rise
      bus.mode = 2'd1;
      cyc(6);
      bus.step_req = 1'b1; nt = 0;
      for (int i = 0; i < 25; i++) begin
         cyc(1);
         if (i == 19) bus.step_req = 1'b0;
         if (bus.tick[0]) nt++;
         if (i == 2) lit("sync_not_yet", 32'(bus.slow_clock), 32'b00);
         if (i == 3) lit("sync_hi_edge4", 32'(bus.slow_clock), 32'b11);
      end
      lit("sync_one_step", 32'(nt), 32'd1);
`else
      nt = 0;
`endif

      chk_en = 1'b0;
      cyc(1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
